gray_tracker: RTL and testbench

Downstream consumer of the 3-bit Gray-code counter stage. Samples the Gray code on each valid strobe, decodes it to binary, classifies each transition as up-step, down-step, hold or illegal jump, and maintains a step-accurate position counter with wrap and error reporting. Sits between the Gray-code source and any logic that needs a monotonic binary position rather than a cyclic code.

---
 rtl/gray_pkg.sv | 25 ++
 rtl/gray2bin.sv | 20 ++
 rtl/gray_tracker.sv | 119 +++++++++++
 tb/tb_gray_tracker.sv | 136 +++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_pkg
// Description : Shared types and default widths for the Gray-code tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package gray_pkg;

  localparam int GRAY_W     = 3;
  localparam int GRAY_CNT_W = 8;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2,
    STEP_BAD  = 2'd3
  } step_t;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/gray2bin.sv
`default_nettype none
// ============================================================================
// Module      : gray2bin
// Description : Combinational Gray-to-binary decoder of parameterised width.
// Revision    : 1.0 - initial release
// ============================================================================
module gray2bin #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule
`default_nettype wire

// File: rtl/gray_tracker.sv
`default_nettype none
// ============================================================================
// Module      : gray_tracker
// Description : Tracks a Gray-code stream as a step-accurate binary position
//               with direction, wrap and sticky illegal-jump reporting.
//               GRAY_TRACKER_SAT_EN: saturate Position instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_tracker
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W,
  parameter int CNT_W = GRAY_CNT_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Valid,
  input  logic [WIDTH-1:0] GrayIn,
  output logic [CNT_W-1:0] Position,
  output logic [WIDTH-1:0] Bin,
  output logic             Step,
  output logic             Dir,
  output logic             Wrap,
  output logic             Error
);

  localparam logic [WIDTH-1:0] BIN_MAX = '1;
  localparam logic [WIDTH-1:0] BIN_ONE = WIDTH'(1);
  localparam logic [CNT_W-1:0] POS_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] bin_q;
  logic [CNT_W-1:0] pos_q;
  logic             step_q;
  logic             dir_q;
  logic             wrap_q;
  logic             err_q;

  logic [WIDTH-1:0] bin_in;
  logic [WIDTH-1:0] delta;
  step_t            step_class;
  logic [CNT_W-1:0] pos_up;
  logic [CNT_W-1:0] pos_dn;

  gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
    .gray (GrayIn),
    .bin  (bin_in)
  );

  assign delta = bin_in - bin_q;

  always_comb begin
    step_class = STEP_BAD;
    if (delta == '0)
      step_class = STEP_HOLD;
    else if (delta == BIN_ONE)
      step_class = STEP_UP;
    else if (delta == BIN_MAX)
      step_class = STEP_DOWN;
  end

`ifdef GRAY_TRACKER_SAT_EN
  assign pos_up = (pos_q == POS_MAX) ? pos_q : pos_q + 1'b1;
  assign pos_dn = (pos_q == '0)      ? pos_q : pos_q - 1'b1;
`else
  assign pos_up = pos_q + 1'b1;
  assign pos_dn = pos_q - 1'b1;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= ST_INIT;
      bin_q  <= '0;
      pos_q  <= '0;
      step_q <= 1'b0;
      dir_q  <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      if (Valid) begin
        // Every accepted sample becomes the new reference, including bad jumps.
        bin_q <= bin_in;
        case (state)
          ST_INIT: state <= ST_TRACK;
          ST_TRACK: begin
            case (step_class)
              STEP_UP: begin
                pos_q  <= pos_up;
                step_q <= 1'b1;
                dir_q  <= 1'b1;
                wrap_q <= (bin_q == BIN_MAX);
              end
              STEP_DOWN: begin
                pos_q  <= pos_dn;
                step_q <= 1'b1;
                dir_q  <= 1'b0;
                wrap_q <= (bin_q == '0);
              end
              STEP_BAD: err_q <= 1'b1;
              default:  ;
            endcase
          end
          default: state <= ST_INIT;
        endcase
      end
    end
  end

  assign Position = pos_q;
  assign Bin      = bin_q;
  assign Step     = step_q;
  assign Dir      = dir_q;
  assign Wrap     = wrap_q;
  assign Error    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_gray_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_tracker
// Description : Directed self-checking bench for gray_tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_tracker;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Valid = 1'b0;
  logic [2:0] GrayIn = 3'b000;
  logic [7:0] Position;
  logic [2:0] Bin;
  logic       Step;
  logic       Dir;
  logic       Wrap;
  logic       Error;

  int checks = 0;
  int errors = 0;

  gray_tracker #(.WIDTH(3), .CNT_W(8)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Valid    (Valid),
    .GrayIn   (GrayIn),
    .Position (Position),
    .Bin      (Bin),
    .Step     (Step),
    .Dir      (Dir),
    .Wrap     (Wrap),
    .Error    (Error)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic feed(input logic [2:0] g);
    Valid  = 1'b1;
    GrayIn = g;
    tick();
    Valid  = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] pos, input logic [2:0] b,
                         input logic st, input logic d, input logic w, input logic e);
    chk({tag, ".pos"},  Position, pos);
    chk({tag, ".bin"},  {5'd0, Bin}, {5'd0, b});
    chk({tag, ".step"}, {7'd0, Step}, {7'd0, st});
    chk({tag, ".dir"},  {7'd0, Dir}, {7'd0, d});
    chk({tag, ".wrap"}, {7'd0, Wrap}, {7'd0, w});
    chk({tag, ".err"},  {7'd0, Error}, {7'd0, e});
  endtask

  initial begin
    logic [7:0] exp_dn_wrap;
`ifdef GRAY_TRACKER_SAT_EN
    exp_dn_wrap = 8'd0;
`else
    exp_dn_wrap = 8'd255;
`endif

    // Reset state
    tick(); tick();
    Reset = 1'b0;
    tick();
    chk_all("reset", 8'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Up count 000,001,011,010
    feed(3'b000); chk_all("first", 8'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    feed(3'b001); chk_all("up1",   8'd1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    feed(3'b011); chk_all("up2",   8'd2, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    feed(3'b010); chk_all("up3",   8'd3, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);

    // Continue to bin 7 then wrap up to 0
    feed(3'b110); feed(3'b111); feed(3'b101); feed(3'b100);
    chk_all("up7", 8'd7, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    feed(3'b000); chk_all("upwrap", 8'd8, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();       chk_all("idle",   8'd8, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Down wrap from fresh reference
    Reset = 1'b1; tick(); Reset = 1'b0;
    feed(3'b000);
    feed(3'b100); chk_all("dnwrap", exp_dn_wrap, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0);

    // Illegal jumps and recovery
    Reset = 1'b1; tick(); Reset = 1'b0;
    feed(3'b000);
    feed(3'b011); chk_all("bad1",    8'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    feed(3'b110); chk_all("bad2",    8'd0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    feed(3'b111); chk_all("recover", 8'd1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1);

    // Hold on repeated code, then Valid low with moving input
    Reset = 1'b1; tick(); Reset = 1'b0;
    feed(3'b000);
    feed(3'b001); chk_all("h_up", 8'd1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    Valid = 1'b1; GrayIn = 3'b001;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all("hold", 8'd1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    Valid = 1'b0;
    GrayIn = 3'b011; tick(); chk_all("novalid1", 8'd1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    GrayIn = 3'b010; tick(); chk_all("novalid2", 8'd1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset together with Valid mid-stream
    feed(3'b011); chk_all("pre_rst", 8'd2, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    Reset = 1'b1; Valid = 1'b1; GrayIn = 3'b010;
    tick();
    Reset = 1'b0; Valid = 1'b0;
    chk_all("rst_valid", 8'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    feed(3'b110); chk_all("new_ref", 8'd0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    feed(3'b111); chk_all("post_up", 8'd1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    feed(3'b101); chk_all("post_up2", 8'd2, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    feed(3'b111); chk_all("post_dn", 8'd1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
